// File: rtl/tlc_control_unit.sv
// tlc_control_unit: ASMD sequencer that steps N/S/E/W through green, yellow and all-red clearance.
// Ports: CU_CLK clock; CU_Rst synchronous active-high reset; CU_Flag datapath phase-timer expired;
//   CU_Req demand {W,E,S,N}; CU_North/South/East/West one-hot approach select; CU_Phase 0 green,
//   1 yellow; CU_Load timer restart strobe; CU_Fault sticky watchdog fault; CU_State debug encoding.
module tlc_control_unit #(
  parameter int ALLRED_CYC = 4,
  parameter int WDT_CYCLES = 1024,
  parameter int CNT_W = 10
) (
  input  logic       CU_CLK,
  input  logic       CU_Rst,
  input  logic       CU_Flag,
  input  logic [3:0] CU_Req,
  output logic       CU_North,
  output logic       CU_South,
  output logic       CU_East,
  output logic       CU_West,
  output logic       CU_Phase,
  output logic       CU_Load,
  output logic       CU_Fault,
  output logic [2:0] CU_State
);
  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    CLEAR   = 3'd3,
    FAULT   = 3'd4
  } state_e;
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d, nxt_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             active, entry, flag_ok;
  assign active  = state_q == GREEN || state_q == YELLOW;
  // The counter is cleared on every phase entry, so zero marks the entry cycle.
  assign entry   = cnt_q == '0;
  assign flag_ok = CU_Flag && !entry;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  // First requester after dir_q in rotation order; the smallest offset is written last and wins.
  always_comb begin
    nxt_dir = dir_q + 2'd1;
    for (int k = 4; k >= 1; k--) if (CU_Req[dir_q + 2'(k)]) nxt_dir = dir_q + 2'(k);
  end
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ALL_RED, CLEAR: begin
        if (cnt_q == AR_LAST) begin
          state_d = GREEN;
          dir_d   = nxt_dir;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      GREEN, YELLOW: begin
        if (flag_ok) begin
          state_d = state_q == GREEN ? YELLOW : CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == WDT_LAST) state_d = FAULT;
        else cnt_d = cnt_inc;
      end
      FAULT: state_d = FAULT;
      default: begin
        state_d = ALL_RED;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge CU_CLK) begin
    if (CU_Rst) begin
      state_q <= ALL_RED;
      dir_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end
  assign CU_North = active && dir_q == 2'd0;
  assign CU_South = active && dir_q == 2'd1;
  assign CU_East  = active && dir_q == 2'd2;
  assign CU_West  = active && dir_q == 2'd3;
  assign CU_Phase = state_q == YELLOW;
  assign CU_Load  = active && entry;
  assign CU_Fault = state_q == FAULT;
  assign CU_State = state_q;
endmodule

// File: tb/tb_tlc_control_unit.sv
// tb_tlc_control_unit: randomized open-loop driver with a Load-event scoreboard and per-cycle output monitor.
module tb_tlc_control_unit;
  localparam int ALLRED = 4;
  localparam int WDT = 16;
  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic       ph;
  } ld_t;
  logic       clk = 1'b0;
  logic       CU_Rst = 1'b1;
  logic       CU_Flag = 1'b0;
  logic [3:0] CU_Req = 4'b0;
  logic       CU_North, CU_South, CU_East, CU_West, CU_Phase, CU_Load, CU_Fault;
  logic [2:0] CU_State;
  int         cyc = 0;
  int         t0 = 0;
  int         tg = ALLRED;
  int         exp_st = 0;
  int         cur_dir = 3;
  logic       chk_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  ld_t        sb[$];
  ld_t        e;
  logic [3:0] sel, exp_sel;
  logic       act;
  tlc_control_unit #(.ALLRED_CYC(ALLRED), .WDT_CYCLES(WDT), .CNT_W(10)) dut (
    .CU_CLK(clk),
    .CU_Rst(CU_Rst),
    .CU_Flag(CU_Flag),
    .CU_Req(CU_Req),
    .CU_North(CU_North),
    .CU_South(CU_South),
    .CU_East(CU_East),
    .CU_West(CU_West),
    .CU_Phase(CU_Phase),
    .CU_Load(CU_Load),
    .CU_Fault(CU_Fault),
    .CU_State(CU_State)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc - t0, a, x);
    end
  endfunction
  // Reference rotation: first requester strictly after d (wrapping back to d), else the plain successor.
  function automatic int next_dir(input int d, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) if (r[(d + k) % 4]) return (d + k) % 4;
    return (d + 1) % 4;
  endfunction
  task automatic step_to(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input int k);
    step_to(k);
    CU_Flag = 1'b1;
    step_to(k + 1);
    CU_Flag = 1'b0;
  endtask
  task automatic do_reset(input int n);
    if (chk_en) chk("scoreboard_drained", sb.size(), 0);
    CU_Rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    CU_Rst = 1'b0;
    CU_Flag = 1'b0;
    t0 = cyc;
    exp_st = 0;
    cur_dir = 3;
    tg = ALLRED;
    chk_en = 1'b1;
  endtask
  task automatic serve(input int n, input logic rnd, input logic [3:0] fr, input int fd, input int fe);
    int d, g, ty, nd;
    for (int i = 0; i < n; i++) begin
      step_to(tg - ALLRED);
      CU_Req = rnd ? 4'($urandom) : fr;
      nd = next_dir(cur_dir, CU_Req);
      if ($urandom_range(1, 0) == 1) pulse(tg - 2);
      step_to(tg);
      cur_dir = nd;
      exp_st = 1;
      sb.push_back('{tg, 4'(1 << nd), 1'b0});
      d = fd > 0 ? fd : int'($urandom_range(WDT - 1, 1));
      if (d >= 2 && $urandom_range(1, 0) == 1) pulse(tg);
      pulse(tg + d);
      ty = tg + d + 1;
      exp_st = 2;
      sb.push_back('{ty, 4'(1 << nd), 1'b1});
      g = fe > 0 ? fe : int'($urandom_range(WDT - 1, 1));
      if (g >= 2 && $urandom_range(1, 0) == 1) pulse(ty);
      pulse(ty + g);
      exp_st = 3;
      tg = ty + g + 1 + ALLRED;
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      sel = {CU_West, CU_East, CU_South, CU_North};
      act = exp_st == 1 || exp_st == 2;
      exp_sel = act ? 4'(1 << cur_dir) : 4'b0;
      chk("state", CU_State, exp_st);
      chk("select", sel, exp_sel);
      chk("select_onehot0", $countones(sel) <= 1, 1);
      chk("fault", CU_Fault, exp_st == 4);
      if (act) chk("phase", CU_Phase, exp_st == 2);
      if (CU_Load) begin
        if (sb.size() == 0) chk("load_unexpected", CU_Load, 0);
        else begin
          e = sb.pop_front();
          chk("load_cycle", cyc - t0, e.cyc);
          chk("load_select", sel, e.sel);
          chk("load_phase", CU_Phase, e.ph);
        end
      end
      chk("load_overdue", sb.size() > 0 && sb[0].cyc < cyc - t0, 0);
    end
  end
  initial begin
    do_reset(3);
    serve(2, 1'b0, 4'b1111, 6, 4);
    do_reset(1);
    serve(4, 1'b0, 4'b1010, 5, 5);
    do_reset(1);
    serve(5, 1'b0, 4'b0000, 0, 0);
    do_reset(1);
    serve(12, 1'b1, 4'b0000, 0, 0);
    do_reset(1);
    CU_Req = 4'b1111;
    step_to(ALLRED);
    cur_dir = 0;
    exp_st = 1;
    sb.push_back('{ALLRED, 4'b0001, 1'b0});
    step_to(ALLRED + WDT);
    exp_st = 4;
    for (int k = ALLRED + WDT; k < ALLRED + WDT + 100; k++) begin
      step_to(k);
      CU_Flag = 1'($urandom);
      CU_Req = 4'($urandom);
    end
    step_to(ALLRED + WDT + 100);
    CU_Flag = 1'b0;
    do_reset(1);
    serve(2, 1'b1, 4'b0000, WDT - 1, WDT - 1);
    do_reset(1);
    CU_Req = 4'b0100;
    step_to(ALLRED);
    cur_dir = 2;
    exp_st = 1;
    sb.push_back('{ALLRED, 4'b0100, 1'b0});
    pulse(ALLRED + 3);
    exp_st = 2;
    sb.push_back('{ALLRED + 4, 4'b0100, 1'b1});
    step_to(ALLRED + 6);
    do_reset(1);
    serve(1, 1'b0, 4'b1111, 0, 0);
    step_to(tg - ALLRED + 1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tlc_control_unit.md
Name: tlc_control_unit

Overview:
- ASMD control unit for the traffic light controller.
- Sequences the four approaches (North, South, East, West) through green, yellow and all-red clearance phases.
- Drives the one-hot direction selects and the timer-load strobe into the TLC datapath, and consumes the datapath's phase-expired flag.
- Adds demand-based skipping of idle approaches and a watchdog that latches a fault if the datapath flag never arrives.

Parameters:
- ALLRED_CYC, 4: cycles spent in ALL_RED (post-reset) and in CLEAR (between approaches); must be ≥1.
- WDT_CYCLES, 1024: maximum cycles allowed in GREEN or YELLOW without CU_Flag before FAULT.
- CNT_W, 10: width of the internal clearance/watchdog counter; must satisfy 2^CNT_W ≥ max(ALLRED_CYC, WDT_CYCLES).

Ports:
- CU_CLK  in  1  system clock; all state changes on the rising edge.
- CU_Rst  in  1  synchronous, active-high reset.
- CU_Flag  in  1  datapath phase-timer expired; single-cycle pulse.
- CU_Req  in  4  approach demand: bit0 N, bit1 S, bit2 E, bit3 W.
- CU_North  out  1  North approach selected (green or yellow).
- CU_South  out  1  South approach selected.
- CU_East  out  1  East approach selected.
- CU_West  out  1  West approach selected.
- CU_Phase  out  1  0 = green, 1 = yellow; valid only while a direction select is high.
- CU_Load  out  1  one-cycle strobe that restarts the datapath phase timer.
- CU_Fault  out  1  sticky watchdog fault.
- CU_State  out  3  encoded state, for debug.

Behaviour:
- Clock and reset:
  - Single clock domain on CU_CLK.
  - CU_Rst is sampled only on the rising edge (synchronous) and is active-high.
- Reset values:
  - state = ALL_RED, dir register = W (so the first served approach is N), counter = 0.
  - All outputs = 0; CU_State = ALL_RED.
- Output style:
  - All outputs are Moore outputs, registered or decoded from registered state. No combinational path from any input to any output.
- States and CU_State encodings:
  - ALL_RED = 0, GREEN = 1, YELLOW = 2, CLEAR = 3, FAULT = 4. Encodings 5–7 are unused and recover to ALL_RED on the next edge.
- ALL_RED / CLEAR:
  - All direction selects are 0; CU_Load = 0.
  - The counter increments from 0. When counter == ALLRED_CYC-1, the next state is GREEN for the next approach, and the counter clears.
- Next-approach selection (evaluated from CU_Req sampled in the last ALL_RED/CLEAR cycle):
  - Choose the first requested approach in rotation order N→S→E→W→N, starting after the current dir.
  - If CU_Req == 0, take the plain next approach in rotation (fixed-time mode).
  - The current approach may be reselected if it is the only requester.
- GREEN:
  - The select for dir is high; CU_Phase = 0.
  - CU_Load = 1 in the first cycle only.
  - CU_Flag in the entry cycle is ignored (treated as stale).
  - CU_Flag high in any later cycle → YELLOW on the next edge.
- YELLOW:
  - Same select; CU_Phase = 1; CU_Load = 1 in the first cycle only.
  - Flag acceptance is identical to GREEN.
  - Accepted flag → CLEAR on the next edge.
- Watchdog:
  - The counter clears on entry to GREEN/YELLOW and increments every cycle without an accepted flag.
  - When counter == WDT_CYCLES-1 and no flag is accepted in that cycle → FAULT on the next edge.
  - If flag and watchdog expiry occur in the same cycle, the flag wins.
- CU_Flag outside GREEN/YELLOW: ignored.
- FAULT:
  - All selects = 0, CU_Load = 0, CU_Fault = 1.
  - Held until CU_Rst; all inputs are ignored.
- Direction selects: at most one of CU_North, CU_South, CU_East, CU_West is high in any cycle.
- Reset mid-operation: the state returns to reset values on the next edge, with no partial phase completion.
- Counter: saturates rather than wrapping; it is never allowed to wrap.

Test Plan:
- Basic startup: CU_Req = 4'b1111, release reset at cycle 0.
  - ALL_RED spans cycles 0–3.
  - Cycle 4: CU_North = 1, CU_Phase = 0, CU_Load = 1.
  - Pulse CU_Flag at cycle 10 → YELLOW at 11 with CU_Load = 1.
  - Flag at 15 → CLEAR spans 16–19.
  - Cycle 20: CU_South = 1, CU_Load = 1.
- Full rotation and skipping: CU_Req = 4'b1010, flag 5 cycles after each Load.
  - Served order is S, W, S, W.
  - N and E are never asserted.
  - Exactly one select is high outside CLEAR/ALL_RED.
- Fixed-time mode: CU_Req = 0 → order is N, S, E, W, N.
- Stale/ignored flags:
  - CU_Flag in the GREEN entry cycle → state stays GREEN.
  - CU_Flag during CLEAR → no effect; the CLEAR length is still 4 cycles.
- Watchdog (WDT_CYCLES = 16):
  - No flag after GREEN entry at cycle 4 → CU_Fault = 1 and all selects = 0 at cycle 20.
  - The fault stays high for 100 cycles despite flags.
  - Flag exactly at cycle 19 → YELLOW instead, with no fault.
- Reset mid-YELLOW on East: assert CU_Rst for 1 cycle → next cycle all outputs = 0 and CU_State = 0; the first green after release is North.
